// File: rtl/fuvrf_loader.sv
// FUVRF port-B writer: assembles address-tagged entries from the byte-serial
// config bus and writes each completed entry into the dual-port FUVRF RAM.
module fuvrf_loader #(
  parameter int unsigned M                  = 8,
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned FUVRF_SIZE         = 4,
  parameter int unsigned PERSONAL_CONFIG_ID = 0,
  localparam int unsigned MEM_WIDTH         = M * DATA_WIDTH,
  localparam int unsigned AW                = $clog2(FUVRF_SIZE)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 tracing,
  input  logic [7:0]           configId,
  input  logic [7:0]           configData,
  output logic [AW-1:0]        mem_address_b,
  output logic [MEM_WIDTH-1:0] mem_in_b,
  output logic                 mem_write_enable_b,
  output logic                 busy,
  output logic                 frame_error,
  output logic [7:0]           write_count
);

  localparam int unsigned BYTES_PER_ENTRY = MEM_WIDTH / 8;
  localparam int unsigned CW              = $clog2(BYTES_PER_ENTRY + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DATA  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 bad_q, bad_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [MEM_WIDTH-1:0] asm_q, asm_d;
  logic [AW-1:0]        mem_address_d;
  logic [MEM_WIDTH-1:0] mem_in_d;
  logic                 wren_d;
  logic                 busy_d;
  logic                 ferr_d;
  logic [7:0]           wc_d;

  logic                 accept_c;
  logic                 addr_bad_c;
  logic [MEM_WIDTH-1:0] shifted_c;

  assign accept_c   = (configId == 8'(PERSONAL_CONFIG_ID)) && !tracing;
  assign addr_bad_c = 32'(configData) >= 32'(FUVRF_SIZE);
  // MSB-first assembly: the first data byte ends up in the top byte lane
  assign shifted_c  = (asm_q << 8) | MEM_WIDTH'(configData);

  // Next-state and next-output logic; the write strobe is raised on the
  // edge that enters WRITE so it is visible for exactly the WRITE cycle.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    bad_d         = bad_q;
    cnt_d         = cnt_q;
    asm_d         = asm_q;
    mem_address_d = mem_address_b;
    mem_in_d      = mem_in_b;
    wren_d        = 1'b0;
    ferr_d        = frame_error;
    wc_d          = write_count;

    case (state_q)
      IDLE, WRITE: begin
        // A byte arriving during WRITE starts the next frame without loss
        if (accept_c) begin
          addr_d  = configData[AW-1:0];
          bad_d   = addr_bad_c;
          cnt_d   = '0;
          ferr_d  = 1'b0;
          state_d = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (tracing) begin
          state_d = IDLE;
          ferr_d  = 1'b1;
        end else if (accept_c) begin
          asm_d = shifted_c;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BYTES_PER_ENTRY - 1)) begin
            state_d = WRITE;
            if (!bad_q) begin
              wren_d        = 1'b1;
              mem_address_d = addr_q;
              mem_in_d      = shifted_c;
              if (write_count != 8'hFF) wc_d = write_count + 8'd1;
            end else begin
              ferr_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q            <= IDLE;
      addr_q             <= '0;
      bad_q              <= 1'b0;
      cnt_q              <= '0;
      asm_q              <= '0;
      mem_address_b      <= '0;
      mem_in_b           <= '0;
      mem_write_enable_b <= 1'b0;
      busy               <= 1'b0;
      frame_error        <= 1'b0;
      write_count        <= '0;
    end else begin
      state_q            <= state_d;
      addr_q             <= addr_d;
      bad_q              <= bad_d;
      cnt_q              <= cnt_d;
      asm_q              <= asm_d;
      mem_address_b      <= mem_address_d;
      mem_in_b           <= mem_in_d;
      mem_write_enable_b <= wren_d;
      busy               <= busy_d;
      frame_error        <= ferr_d;
      write_count        <= wc_d;
    end
  end

endmodule
